// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex driver for a NUM_DIGITS seven-segment display.
// It latches value/dp/blink on load, scans one digit per SCAN_DIV-cycle slot and drives registered pins.
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 4,
  parameter int BLINK_FRAMES   = 8,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    e,
  output logic                    f,
  output logic                    g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   di,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // Inactive pin levels; XOR with these applies polarity as the very last step.
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [DW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blink;

  logic                    div_wrap;
  logic                    idx_wrap;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    upper_zero;
  logic                    blank_digit;
  logic                    blink_off;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   di_next;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  assign div_wrap = (div_cnt == DIV_LAST);
  assign idx_wrap = div_wrap && (idx == IDX_LAST);

  // upper_zero: the selected digit and every higher-index digit hold zero.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    di_next    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = shadow_val[4*i +: 4];
        cur_dp     = shadow_dp[i];
        cur_blink  = shadow_blink[i];
        di_next[i] = 1'b1;
      end
      if ((IW'(i) >= idx) && (shadow_val[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    blank_digit = blank_lz && (idx != '0) && upper_zero;
    blink_off   = blink_phase && cur_blink;
    seg_next    = (blank_digit || blink_off) ? 7'b0000000 : decode(cur_nib);
    dp_next     = cur_dp && !blink_off;
    if (blink_off) di_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (idx_wrap) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // load is a plain strobe with no back-pressure: it is sampled every edge and never disturbs the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blink <= '0;
    end else if (load) begin
      shadow_val   <= value_in;
      shadow_dp    <= dp_in;
      shadow_blink <= blink_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {a, b, c, d, e, f, g} <= {7{SEG_OFF}};
      dp                    <= SEG_OFF;
      di                    <= {NUM_DIGITS{DIG_OFF}};
      frame_tick            <= 1'b0;
    end else begin
      {a, b, c, d, e, f, g} <= seg_next ^ {7{SEG_OFF}};
      dp                    <= dp_next ^ SEG_OFF;
      di                    <= di_next ^ {NUM_DIGITS{DIG_OFF}};
      frame_tick            <= idx_wrap;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed literal checks plus randomized traffic
// compared every cycle against a slot/frame arithmetic model.
module tb_seven_segment_scanner;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam logic SEG_INV = 1'b0;
  localparam logic DIG_INV = 1'b1;
  localparam logic [12:0] RESET_VEC = {7'b0000000, 1'b0, 4'b1111, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value_in = 16'h0;
  logic [3:0]    dp_in = 4'h0;
  logic [3:0]    blink_mask = 4'h0;
  logic          blank_lz = 1'b0;
  logic          a, b, c, d, e, f, g, dp;
  logic [3:0]    di;
  logic          frame_tick;
  logic [6:0]    seg_act;
  logic [12:0]   act_vec;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_scanner #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .blank_lz(blank_lz),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .di(di), .frame_tick(frame_tick)
  );

  assign seg_act = {a, b, c, d, e, f, g};
  assign act_vec = {seg_act, dp, di, frame_tick};

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]  seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [3:0]  sh_val [N] = '{default: 4'h0};
  logic [N-1:0] sh_dp = '0;
  logic [N-1:0] sh_bl = '0;
  int          t = 0;
  logic [12:0] exp_q[$];

  always @(negedge rst_n) begin
    t = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) sh_val[i] = 4'h0;
    sh_dp = '0;
    sh_bl = '0;
  end

  // t counts edges since reset; the outputs after edge t+1 show the slot active during cycle t.
  always @(posedge clk) begin
    int sel, frame, phase;
    logic blank, boff, p, ft;
    logic [6:0] s;
    logic [3:0] dv;
    if (rst_n) begin
      sel   = (t / SD) % N;
      frame = t / (SD * N);
      phase = (frame / BF) % 2;
      blank = blank_lz && (sel != 0);
      for (int j = sel; j < N; j++) if (sh_val[j] != 4'h0) blank = 1'b0;
      boff  = (phase == 1) && sh_bl[sel];
      s     = (boff || blank) ? 7'b0 : seg_tab[sh_val[sel]];
      p     = !boff && sh_dp[sel];
      dv    = boff ? 4'b0000 : 4'(1 << sel);
      ft    = ((t + 1) % (SD * N)) == 0;
      exp_q.push_back({s ^ {7{SEG_INV}}, p ^ SEG_INV, dv ^ {4{DIG_INV}}, ft});
      if (load) begin
        for (int i = 0; i < N; i++) sh_val[i] = value_in[4*i +: 4];
        sh_dp = dp_in;
        sh_bl = blink_mask;
      end
      t++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) check("reset_outputs", act_vec, RESET_VEC);
    else if (exp_q.size() > 0) check("scan_outputs", act_vec, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [15:0] v, input logic [3:0] p, input logic [3:0] bm);
    @(negedge clk);
    value_in   = v;
    dp_in      = p;
    blink_mask = bm;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic wait_di(input logic [3:0] target);
    bit hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (di == target) hit = 1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_di: timeout, di=%b required %b", di, target);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", act_vec, RESET_VEC);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_literal", act_vec, RESET_VEC);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_digit0_seg", {6'd0, seg_act}, {6'd0, 7'b1111110});
    check("first_digit0_di", {9'd0, di}, {9'd0, 4'b1110});

    load_word(16'h9A3F, 4'b0100, 4'b0000);
    wait_di(4'b1011);
    check("hex_digit2_A", {5'd0, seg_act, dp}, {5'd0, 7'b1110111, 1'b1});
    wait_di(4'b0111);
    check("hex_digit3_9", {5'd0, seg_act, dp}, {5'd0, 7'b1111011, 1'b0});
    wait_di(4'b1110);
    check("hex_digit0_F", {5'd0, seg_act, dp}, {5'd0, 7'b1000111, 1'b0});
    wait_di(4'b1101);
    check("hex_digit1_3", {6'd0, seg_act}, {6'd0, 7'b1111001});

    blank_lz = 1'b1;
    load_word(16'h0050, 4'b0000, 4'b0000);
    wait_di(4'b0111);
    check("lz_digit3_blank", {6'd0, seg_act}, 13'd0);
    wait_di(4'b1011);
    check("lz_digit2_blank", {6'd0, seg_act}, 13'd0);
    wait_di(4'b1101);
    check("lz_digit1_5", {6'd0, seg_act}, {6'd0, 7'b1011011});
    wait_di(4'b1110);
    check("lz_digit0_0", {6'd0, seg_act}, {6'd0, 7'b1111110});

    load_word(16'h0000, 4'b0010, 4'b0000);
    wait_di(4'b1101);
    check("lz_zero_digit1_dp_only", {5'd0, seg_act, dp}, {5'd0, 7'b0000000, 1'b1});
    wait_di(4'b1110);
    check("lz_zero_digit0_lit", {6'd0, seg_act}, {6'd0, 7'b1111110});
    blank_lz = 1'b0;

    async_reset();

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) async_reset();
      load = ($urandom_range(7) == 0);
      if (load) begin
        for (int k = 0; k < N; k++)
          value_in[4*k +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
        dp_in      = 4'($urandom_range(15));
        blink_mask = 4'($urandom_range(15)) & 4'($urandom_range(15));
      end
      if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Time-multiplexed driver for a NUM_DIGITS-digit common-anode/cathode seven-segment display. Latches a packed hex value and decimal points on a load strobe, scans one digit per refresh slot, decodes 0-F to segments, and supports leading-zero blanking and per-digit blinking. Sits between control logic and the board display pins, replacing the single-digit combinational decoder.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
SCAN_DIV, 4, clock cycles per digit slot (>=1)
BLINK_FRAMES, 8, full scan frames per blink half-period (>=1)
SEG_ACTIVE_LOW, 0, 1 = segment/dp outputs driven low when lit
DIG_ACTIVE_LOW, 1, 1 = digit-select output driven low when selected

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  when high at a clk edge, capture value_in, dp_in, blink_mask
value_in  input  4*NUM_DIGITS  packed nibbles, digit 0 = bits [3:0]
dp_in  input  NUM_DIGITS  decimal point per digit
blink_mask  input  NUM_DIGITS  1 = digit blinks
blank_lz  input  1  leading-zero blanking enable (live, not latched)
a,b,c,d,e,f,g  output  1 each  segment drives (registered)
dp  output  1  decimal point drive (registered)
di  output  NUM_DIGITS  digit select, one-hot at active level (registered)
frame_tick  output  1  one-cycle pulse when scan wraps to digit 0

Behaviour:
- Reset (rst_n=0, async): div counter=0, digit index idx=0, shadow value/dp/blink=0, blink phase=0, frame counter=0; all segments and dp at inactive level; di all inactive; frame_tick=0.
- Div counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and idx advances (NUM_DIGITS-1 wraps to 0). SCAN_DIV=1: idx advances every cycle.
- frame_tick=1 for the single cycle following the edge where idx wraps to 0.
- Frame counter increments on each idx wrap; at BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
- load: shadow registers updated at that edge; load held high reloads every cycle. load does not reset the scan.
- Output registers update every cycle from shadow[idx] using current idx, so outputs lag idx by 1 cycle. New load data appears on outputs 1 edge after capture if its digit is selected.
- di: bit idx at active level, all others inactive.
- Decode abcdefg (1=lit): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- Leading-zero blanking (blank_lz=1): a digit is blanked (a-g off) if it and every higher-index digit hold 0. Digit 0 is never blanked. dp of a blanked digit still follows shadow dp.
- Blink: when blink phase=1 and shadow blink bit of the selected digit=1, a-g and dp are off and di stays inactive for that slot.
- Polarity applied last: SEG_ACTIVE_LOW inverts a-g and dp; DIG_ACTIVE_LOW inverts di.
- Reset mid-scan: immediate return to reset values. First post-reset edge shows digit 0 = '0' (a-f lit, g off).

Test Plan:
- Reset then release, NUM_DIGITS=4, SCAN_DIV=4, no load -> di cycles 1110,1101,1011,0111 every 4 clocks. Digit 0 shows abcdefg=1111110, digits 1-3 same. frame_tick pulses every 16 clocks.
- load value_in=16'h9A3F, dp_in=4'b0100 -> slots show F(1000111), 3(1111001), A(1110111) with dp=1 on digit 2, 9(1111011); dp=0 on the other digits.
- value_in=16'h0050, blank_lz=1 -> digits 3 and 2 a-g off, digit 1 = 5, digit 0 = 0 shown. With value 16'h0000, only digit 0 is lit.
- blink_mask=4'b0001, BLINK_FRAMES=2 -> digit 0 lit for 2 frames (32 clocks), then dark with di inactive for 2 frames, then repeats. Other digits are unaffected.
- Load during slot of digit 1 changing its nibble 2->7 -> segment outputs change 1 clock after the load edge, with no slot misalignment.
- Assert rst_n low mid-slot between clock edges -> outputs go inactive immediately without waiting for a clk edge. After release, scan restarts at digit 0 with counter 0.
